// File: rtl/mux_arb_n.sv
// Registered N-channel word selector: direct select or arbitration into a one-entry valid/ready output.
// Define MUX_ARB_RR_EN for round-robin arbitration; otherwise the lowest valid index wins.
module mux_arb_n #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [SELW-1:0]   chosen;
  logic              has_choice;
  logic              ld;
  logic              xfer;
`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0]   ptr_q, ptr_d;
  int unsigned       idx;
`endif

  always_comb begin
    ld         = (state_q == EMPTY) | out_ready;
    chosen     = '0;
    has_choice = 1'b0;
`ifdef MUX_ARB_RR_EN
    idx        = 0;
`endif
    if (!mode) begin
      // Out-of-range codes (possible when NCH is not a power of two) select nothing.
      if (32'(sel) < NCH) begin
        chosen     = sel;
        has_choice = 1'b1;
      end
    end else begin
`ifdef MUX_ARB_RR_EN
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = (32'(ptr_q) + k) % NCH;
        if (!has_choice && in_valid[SELW'(idx)]) begin
          chosen     = SELW'(idx);
          has_choice = 1'b1;
        end
      end
`else
      for (int unsigned k = 0; k < NCH; k++) begin
        if (!has_choice && in_valid[SELW'(k)]) begin
          chosen     = SELW'(k);
          has_choice = 1'b1;
        end
      end
`endif
    end

    xfer     = has_choice & in_valid[chosen] & ld;
    in_ready = '0;
    if (has_choice) in_ready[chosen] = ld;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer) begin
      state_d = FULL;
      data_d  = in_data[chosen*WIDTH +: WIDTH];
      ch_d    = chosen;
    end else if (ld) begin
      state_d = EMPTY;
    end
  end

`ifdef MUX_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (mode && xfer) ptr_d = (32'(chosen) == NCH - 1) ? '0 : chosen + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
`ifdef MUX_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
`ifdef MUX_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: doc/mux_arb_n.md
# mux_arb_n

Parametrised, registered N-channel word selector that succeeds the combinational 8:1 datapath muxes. It accepts one word per cycle from NCH valid/ready source channels, either by an explicit select code (direct mode) or by arbitration among requesting channels (arbitrated mode). The chosen word sits in a single-entry output register with a valid/ready handshake to the consumer. The block sits between multiple producers (register-file, ALU and memory paths) and one shared downstream consumer.

## Interface
- WIDTH, 32, data word width in bits
- NCH, 8, number of source channels (2..16)
- SELW, $clog2(NCH), width of select and channel-ID fields

- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  NCH*WIDTH  channel i word at [i*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel word-valid
- in_ready  out  NCH  per-channel accept, combinational
- mode  in  1  0 = direct select, 1 = arbitrated
- sel  in  SELW  channel code, used in direct mode only
- out_data  out  WIDTH  registered selected word
- out_valid  out  1  out_data holds an unconsumed word
- out_ready  in  1  consumer accepts out_data this cycle
- out_ch  out  SELW  index of the channel that supplied out_data

## Operation
- Load enable: ld = ~out_valid | out_ready. The output register is empty, or it drains in the same cycle.
- Direct mode (mode=0):
  - in_ready[sel] = ld; every other in_ready bit = 0.
  - Transfer occurs when in_valid[sel] & ld.
  - A sel value >= NCH selects nothing: all in_ready = 0 and no transfer.
- Arbitrated mode (mode=1):
  - grant = first channel with in_valid set, searching upward from the priority pointer ptr and wrapping from NCH-1 to 0.
  - in_ready[grant] = ld; all other bits = 0. If no channel is valid, all bits = 0.
  - After each arbitrated transfer, ptr <= (grant+1) mod NCH.
  - ptr holds its value in direct mode and in cycles with no transfer.
- On a transfer: out_data <= chosen word; out_ch <= chosen index; out_valid <= 1.
- If ld=1 and there is no transfer: out_valid <= 0. out_data and out_ch keep their last values.
- If ld=0: all output registers hold.
- Output-register states:
  - EMPTY to FULL on a transfer.
  - FULL to FULL on drain with a simultaneous transfer.
  - FULL to EMPTY on drain without a transfer.
- in_ready may depend on in_valid in arbitrated mode. Sources must not make in_valid depend on in_ready.
- mode and sel are sampled every cycle and have no internal latching. A change takes effect on the next arbitration.

## Timing
- Reset asserted (reset=0), asynchronously: out_valid=0, out_data=0, out_ch=0, ptr=0. A buffered word is discarded.
- After reset: ld=1, so in_ready follows the mode/sel/grant rules above immediately.
- Latency: the word accepted in cycle t appears on out_data with out_valid=1 in cycle t+1.
- Throughput: one word per cycle while out_ready=1, with no bubbles.
- While out_valid=1 and out_ready=0, out_data and out_ch are stable and every in_ready bit = 0.
- Drain and load in the same cycle: the new word replaces the old one at the edge, and out_valid stays 1.
- Reset released mid-stream: the first transfer is allowed in the first cycle after deassertion.

## Configuration
- MUX_ARB_RR_EN defined: arbitrated mode uses the round-robin pointer ptr as described.
- MUX_ARB_RR_EN undefined: arbitrated mode is fixed priority, with the lowest valid index winning. No ptr register is instantiated. Direct mode is unchanged.

## Test plan
- Reset and direct mode:
  - Stimulus: reset=0, then release; mode=0, sel=3, in_valid=8'h08, ch3 word 32'hDEADBEEF, out_ready=1.
  - Response: during reset, outputs are 0. One cycle after release, out_valid=1, out_data=32'hDEADBEEF, out_ch=3.
- Backpressure:
  - Stimulus: full register with out_ready=0 for 3 cycles, then out_ready=1 with a new ch3 word 32'h12345678.
  - Response: in_ready=8'h00 and out_data is held. On the next cycle out_data=32'h12345678, with no empty cycle.
- Direct mode, unselected channel invalid:
  - Stimulus: sel=2, in_valid=8'hFB, out_ready=1.
  - Response: in_ready=8'h04, no transfer, out_valid=0 on the next cycle.
- Round-robin under full load:
  - Stimulus: mode=1, in_valid=8'hFF held, out_ready=1.
  - Response: out_ch sequence 0,1,…,7,0. With MUX_ARB_RR_EN undefined, the sequence is 0,0,0,….
- Wrap-around skip:
  - Stimulus: mode=1, in_valid=8'h81, ptr=1 (after a ch0 grant).
  - Response: grants go to ch7, then ch0, then ch7.
- Reset mid-operation:
  - Stimulus: assert reset while out_valid=1 and ptr=5.
  - Response: out_valid=0 without waiting for a clock edge. After release, the first arbitrated grant starts its search at ch0.
